// File: rtl/spi_pixel_ctrl.sv
// Command sequencer: splits each CS-low SPI byte stream into pixel writes and WS2812 frame starts.
// Latency: write strobe 1 clk after the 3rd colour byte; o_tx_start 4 clks after the i_cs rise when idle.
// Backpressure: none on incoming bytes; frame starts wait for !i_tx_busy, extra shows coalesce into one.
module spi_pixel_ctrl #(
    parameter int NUM_PIXELS = 64,
    parameter int ADDR_W     = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [7:0]        i_rx_data,
    input  logic              i_data_valid,
    input  logic              i_cs,
    input  logic              i_tx_busy,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [23:0]       o_wr_data,
    output logic              o_tx_start,
    output logic              o_show_pend,
    output logic [2:0]        o_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_IDX,
        ST_PIX,
        ST_DROP
    } state_t;

    localparam logic [8:0] NUM_PIX_9 = 9'(NUM_PIXELS);

    logic [1:0]  cs_sync;
    logic        cs_d;
    logic        cs_s;
    logic        cs_fall;
    logic        cs_rise;

    state_t      state, state_nxt;
    logic        show_flag, show_nxt;
    logic [7:0]  addr, addr_nxt;
    logic [1:0]  bc, bc_nxt;
    logic [15:0] col, col_nxt;
    logic [2:0]  err_nxt;
    logic        wr_fire;
    logic        pend_set;
    logic        pending;

    assign cs_s        = cs_sync[1];
    assign cs_fall     = ~cs_s & cs_d;
    assign cs_rise     = cs_s & ~cs_d;
    assign o_show_pend = pending;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cs_sync <= 2'b11;
            cs_d    <= 1'b1;
        end else begin
            cs_sync <= {cs_sync[0], i_cs};
            cs_d    <= cs_sync[1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A byte landing in the closing cycle is parsed first, then the close is applied on top.
    always_comb begin
        state_nxt = state;
        show_nxt  = show_flag;
        addr_nxt  = addr;
        bc_nxt    = bc;
        col_nxt   = col;
        err_nxt   = o_err;
        wr_fire   = 1'b0;
        pend_set  = 1'b0;

        if (i_data_valid) begin
            case (state)
                ST_CMD: begin
                    case (i_rx_data)
                        8'h00: begin
                            state_nxt = ST_DROP;
                            err_nxt   = 3'b000;
                        end
                        8'h01: state_nxt = ST_IDX;
                        8'h02: begin
                            state_nxt = ST_DROP;
                            show_nxt  = 1'b1;
                        end
                        8'h03: begin
                            state_nxt = ST_IDX;
                            show_nxt  = 1'b1;
                        end
                        default: begin
                            state_nxt  = ST_DROP;
                            err_nxt[2] = 1'b1;
                        end
                    endcase
                end
                ST_IDX: begin
                    addr_nxt  = i_rx_data;
                    bc_nxt    = 2'd0;
                    state_nxt = ST_PIX;
                end
                ST_PIX: begin
                    case (bc)
                        2'd0: begin
                            col_nxt[15:8] = i_rx_data;
                            bc_nxt        = 2'd1;
                        end
                        2'd1: begin
                            col_nxt[7:0] = i_rx_data;
                            bc_nxt       = 2'd2;
                        end
                        default: begin
                            bc_nxt = 2'd0;
                            if ({1'b0, addr} < NUM_PIX_9) begin
                                wr_fire = 1'b1;
                            end else begin
                                err_nxt[0] = 1'b1;
                            end
                            addr_nxt = (addr == 8'hFF) ? 8'hFF : addr + 8'd1;
                        end
                    endcase
                end
                default: ;
            endcase
        end

        if (cs_fall && state == ST_IDLE) begin
            state_nxt = ST_CMD;
        end

        if (cs_rise) begin
            state_nxt = ST_IDLE;
            if (state == ST_PIX && bc_nxt != 2'd0) begin
                err_nxt[1] = 1'b1;
            end
            bc_nxt   = 2'd0;
            pend_set = show_nxt;
            show_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            show_flag  <= 1'b0;
            addr       <= 8'd0;
            bc         <= 2'd0;
            col        <= 16'd0;
            o_err      <= 3'b000;
            o_wr_en    <= 1'b0;
            o_wr_addr  <= '0;
            o_wr_data  <= 24'd0;
            o_tx_start <= 1'b0;
            pending    <= 1'b0;
        end else begin
            show_flag  <= show_nxt;
            addr       <= addr_nxt;
            bc         <= bc_nxt;
            col        <= col_nxt;
            o_err      <= err_nxt;
            o_wr_en    <= wr_fire;
            if (wr_fire) begin
                o_wr_addr <= addr[ADDR_W-1:0];
                o_wr_data <= {col, i_rx_data};
            end
            // A show closing while one is already pending merges into it.
            o_tx_start <= 1'b0;
            if (pending) begin
                if (!i_tx_busy) begin
                    o_tx_start <= 1'b1;
                    pending    <= 1'b0;
                end
            end else if (pend_set) begin
                pending <= 1'b1;
            end
        end
    end

endmodule
